// File: rtl/wfq_rd_pkg.sv
// ---------------------------------------------------------------------------
// wfq_rd_pkg
//   Shared definitions for the WFQ dequeue reader:
//     - wfq_rd_state_e : reader FSM state encoding
//     - default flow count, data width and read latency
//     - bytes carried by one default-width data word
//     - sat_add()      : saturating adder used by all service counters
// ---------------------------------------------------------------------------
package wfq_rd_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        SPACE = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } wfq_rd_state_e;

    localparam int unsigned WFQ_RD_DEF_NUM_FLOWS  = 4;
    localparam int unsigned WFQ_RD_DEF_DATA_W     = 64;
    localparam int unsigned WFQ_RD_DEF_RD_LATENCY = 7;
    localparam int unsigned WFQ_RD_BYTES_PER_WORD = WFQ_RD_DEF_DATA_W / 8;

    // Adds inc to a and clamps the result at max_val. Operands are carried in
    // 64 bits with one extra bit for the carry, so any counter up to 64 bits
    // wide can use it without wrapping.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] inc,
                                            input logic [63:0] max_val);
        logic [64:0] sum;
        sum = {1'b0, a} + {1'b0, inc};
        if (sum > {1'b0, max_val}) begin
            return max_val;
        end
        return sum[63:0];
    endfunction

endpackage

// File: rtl/wfq_rd_latency_pipe.sv
// ---------------------------------------------------------------------------
// wfq_rd_latency_pipe
//   Shift register that tracks every issued read request until its data word
//   comes back from the scheduler.
//   Ports:
//     clk      in   system clock
//     rst      in   synchronous active-high reset; drops all in-flight entries
//     req_in   in   read request issued this cycle
//     tap_out  out  high in the cycle whose closing edge carries the returned
//                   word (RD_LATENCY edges after the request edge)
//     pending  out  at least one request is still in flight
// ---------------------------------------------------------------------------
module wfq_rd_latency_pipe
    import wfq_rd_pkg::*;
#(
    parameter int unsigned RD_LATENCY = WFQ_RD_DEF_RD_LATENCY
) (
    input  logic clk,
    input  logic rst,
    input  logic req_in,
    output logic tap_out,
    output logic pending
);

    logic [RD_LATENCY-1:0] pipe_q;

    generate
        if (RD_LATENCY == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q <= req_in;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q <= {pipe_q[RD_LATENCY-2:0], req_in};
                end
            end
        end
    endgenerate

    // Bit k is set k+1 edges after the request edge, so the top bit is high
    // during the cycle that ends on the data-valid edge.
    assign tap_out = pipe_q[RD_LATENCY-1];
    assign pending = |pipe_q;

endmodule

// File: rtl/wfq_dequeue_reader.sv
// ---------------------------------------------------------------------------
// wfq_dequeue_reader
//   Dequeue-side client of the WFQ scheduler. On start it issues num_reads
//   paced single-cycle read requests while the packet buffer is non-empty,
//   captures each returned word RD_LATENCY edges later, classifies it by flow
//   index and keeps saturating per-flow, total and unknown service counters.
//
//   Read interface: rd_req is a one-cycle request, only asserted while
//   buffer_empty is low (buffer_empty acts as an inverted ready). The
//   scheduler has no back-pressure on the return path: the word for a request
//   sampled at edge N is taken from data_in at edge N+RD_LATENCY, with no
//   valid strobe; the reader tracks validity itself.
//
//   Optional feature (macro WFQ_RD_BYTE_COUNT_EN):
//     defined   - counters advance by DATA_W/8 per word (bytes served)
//     undefined - counters advance by 1 per word
//
//   Ports:
//     clk          in   system clock
//     rst          in   synchronous active-high reset
//     start        in   one-cycle pulse, begins a run (ignored while busy)
//     num_reads    in   requests in the run, sampled with start
//     buffer_empty in   scheduler packet buffer empty flag
//     data_in      in   scheduler output data
//     rd_req       out  read request pulse
//     busy         out  run in progress
//     done         out  one-cycle pulse at the end of a run
//     cnt_sel      in   flow selector for cnt_out
//     cnt_out      out  service counter of the selected flow
//     total_out    out  sum of all flow counters
//     unknown_out  out  words that did not map to a valid flow
//     state_dbg    out  current FSM state
// ---------------------------------------------------------------------------
module wfq_dequeue_reader
    import wfq_rd_pkg::*;
#(
    parameter int unsigned NUM_FLOWS  = WFQ_RD_DEF_NUM_FLOWS,
    parameter int unsigned DATA_W     = WFQ_RD_DEF_DATA_W,
    parameter int unsigned RD_LATENCY = WFQ_RD_DEF_RD_LATENCY,
    parameter int unsigned GAP        = 1,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned NREQ_W     = 16,
    localparam int unsigned FIDX_W    = (NUM_FLOWS > 1) ? $clog2(NUM_FLOWS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NREQ_W-1:0]   num_reads,
    input  logic                buffer_empty,
    input  logic [DATA_W-1:0]   data_in,
    output logic                rd_req,
    output logic                busy,
    output logic                done,
    input  logic [FIDX_W-1:0]   cnt_sel,
    output logic [CNT_W-1:0]    cnt_out,
    output logic [CNT_W-1:0]    total_out,
    output logic [CNT_W-1:0]    unknown_out,
    output wfq_rd_state_e       state_dbg
);

    localparam logic [63:0] CNT_MAX =
        (CNT_W >= 64) ? {64{1'b1}} : ((64'd1 << CNT_W) - 64'd1);

`ifdef WFQ_RD_BYTE_COUNT_EN
    localparam logic [63:0] INC = 64'(DATA_W / 8);
`else
    localparam logic [63:0] INC = 64'd1;
`endif

    localparam int unsigned       GAP_W       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST    = GAP_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [FIDX_W:0]   NUM_FLOWS_X = (FIDX_W + 1)'(NUM_FLOWS);

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    wfq_rd_state_e      state_q, state_d;
    logic [NREQ_W-1:0]  remaining_q;
    logic [GAP_W-1:0]   gap_q;
    logic               clear_cnt;
    logic               pending;
    logic               tap;

    assign clear_cnt = (state_q == IDLE) && start;

    always_comb begin
        state_d = state_q;
        rd_req  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (num_reads == '0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                if (!buffer_empty) begin
                    rd_req = 1'b1;
                    // With no gap the SPACE state is skipped entirely so that
                    // requests can go out back to back.
                    if (GAP == 0) begin
                        state_d = (remaining_q == NREQ_W'(1)) ? DRAIN : ISSUE;
                    end else begin
                        state_d = SPACE;
                    end
                end
            end
            SPACE: begin
                if (gap_q == GAP_LAST) begin
                    state_d = (remaining_q == '0) ? DRAIN : ISSUE;
                end
            end
            DRAIN: begin
                if (!pending) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            gap_q       <= '0;
        end else begin
            state_q <= state_d;
            if (clear_cnt) begin
                remaining_q <= num_reads;
            end else if (rd_req) begin
                remaining_q <= remaining_q - NREQ_W'(1);
            end
            if (state_q == SPACE) begin
                gap_q <= gap_q + GAP_W'(1);
            end else begin
                gap_q <= '0;
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign state_dbg = state_q;

    // -----------------------------------------------------------------------
    // Return-data alignment
    // -----------------------------------------------------------------------
    wfq_rd_latency_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .req_in  (rd_req),
        .tap_out (tap),
        .pending (pending)
    );

    // -----------------------------------------------------------------------
    // Classification and service counters
    // -----------------------------------------------------------------------
    logic [FIDX_W-1:0] word_idx;
    logic              word_known;
    logic [CNT_W-1:0]  cnt_q [NUM_FLOWS];
    logic [CNT_W-1:0]  total_q;
    logic [CNT_W-1:0]  unknown_q;

    assign word_idx   = data_in[FIDX_W-1:0];
    // A word belongs to a flow only if it is a small integer naming an
    // existing flow; anything else (stray upper bits, out-of-range index)
    // goes to the unknown counter.
    assign word_known = (data_in[DATA_W-1:FIDX_W] == '0) &&
                        ({1'b0, word_idx} < NUM_FLOWS_X);

    always_ff @(posedge clk) begin
        if (rst || clear_cnt) begin
            for (int i = 0; i < int'(NUM_FLOWS); i++) begin
                cnt_q[i] <= '0;
            end
            total_q   <= '0;
            unknown_q <= '0;
        end else if (tap) begin
            if (word_known) begin
                for (int i = 0; i < int'(NUM_FLOWS); i++) begin
                    if (word_idx == FIDX_W'(i)) begin
                        cnt_q[i] <= CNT_W'(sat_add(64'(cnt_q[i]), INC, CNT_MAX));
                    end
                end
                total_q <= CNT_W'(sat_add(64'(total_q), INC, CNT_MAX));
            end else begin
                unknown_q <= CNT_W'(sat_add(64'(unknown_q), INC, CNT_MAX));
            end
        end
    end

    always_comb begin
        cnt_out = '0;
        for (int i = 0; i < int'(NUM_FLOWS); i++) begin
            if (cnt_sel == FIDX_W'(i)) begin
                cnt_out = cnt_q[i];
            end
        end
    end

    assign total_out   = total_q;
    assign unknown_out = unknown_q;

endmodule

// File: tb/tb_wfq_dequeue_reader.sv
module tb_wfq_dequeue_reader;
    import wfq_rd_pkg::*;

    localparam int NUM_FLOWS  = 4;
    localparam int DATA_W     = 64;
    localparam int RD_LATENCY = 7;
    localparam int GAP        = 1;
    localparam int CNT_W      = 32;
    localparam int NREQ_W     = 16;
    localparam int FIDX_W     = 2;
`ifdef WFQ_RD_BYTE_COUNT_EN
    localparam int INC = 8;
`else
    localparam int INC = 1;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic               start = 1'b0;
    logic [NREQ_W-1:0]  num_reads = '0;
    logic               buffer_empty = 1'b0;
    logic [DATA_W-1:0]  data_in = '0;
    logic               rd_req, busy, done;
    logic [FIDX_W-1:0]  cnt_sel = '0;
    logic [CNT_W-1:0]   cnt_out, total_out, unknown_out;
    wfq_rd_state_e      state_dbg;

    wfq_dequeue_reader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_reads    (num_reads),
        .buffer_empty (buffer_empty),
        .data_in      (data_in),
        .rd_req       (rd_req),
        .busy         (busy),
        .done         (done),
        .cnt_sel      (cnt_sel),
        .cnt_out      (cnt_out),
        .total_out    (total_out),
        .unknown_out  (unknown_out),
        .state_dbg    (state_dbg)
    );

    // ---------------- bookkeeping ----------------
    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int done_cnt    = 0;
    int done_cyc    = 0;
    int req_q[$];
    logic [DATA_W-1:0] word_q[$];

    typedef struct {
        int               due;
        logic [DATA_W-1:0] word;
    } pend_t;
    pend_t pend_q[$];
    int    cap_q[$];
    logic [2*CNT_W-1:0] exp_q[$];   // {unknown, total} after each capture

    int mdl_flow [NUM_FLOWS];
    int mdl_total = 0;
    int mdl_unk   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- model scheduler ----------------
    always @(posedge clk) begin
        logic [DATA_W-1:0] w;
        cyc = cyc + 1;
        if (rst) begin
            pend_q.delete();
            cap_q.delete();
            exp_q.delete();
        end else begin
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
            if (rd_req) begin
                check("req_while_empty", 64'(buffer_empty), 64'd0);
                req_q.push_back(cyc);
                if (word_q.size() > 0) w = word_q.pop_front();
                else w = '0;
                if (w < DATA_W'(NUM_FLOWS)) begin
                    mdl_flow[w[FIDX_W-1:0]] += INC;
                    mdl_total += INC;
                end else begin
                    mdl_unk += INC;
                end
                pend_q.push_back('{due: cyc + RD_LATENCY, word: w});
                cap_q.push_back(cyc + RD_LATENCY);
                exp_q.push_back({CNT_W'(mdl_unk), CNT_W'(mdl_total)});
            end
        end
        if (pend_q.size() > 0 && pend_q[0].due == cyc + 1) begin
            data_in <= pend_q[0].word;
            void'(pend_q.pop_front());
        end else begin
            data_in <= {$urandom, $urandom};
        end
    end

    // ---------------- scoreboard: per-word capture check ----------------
    always @(posedge clk) begin
        logic [2*CNT_W-1:0] e;
        #1;
        if (cap_q.size() > 0 && cap_q[0] == cyc) begin
            void'(cap_q.pop_front());
            e = exp_q.pop_front();
            check("word_total",   64'(total_out),   64'(e[CNT_W-1:0]));
            check("word_unknown", 64'(unknown_out), 64'(e[2*CNT_W-1:CNT_W]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_run(input int n);
        for (int i = 0; i < NUM_FLOWS; i++) mdl_flow[i] = 0;
        mdl_total = 0;
        mdl_unk   = 0;
        req_q.delete();
        done_cnt  = 0;
        num_reads = NREQ_W'(n);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clk);
        check(tag, 64'(done_cnt > 0), 64'd1);
    endtask

    task automatic check_counts(input string tag, input int f0, input int f1,
                                input int f2, input int f3, input int tot, input int unk);
        int exp_f [NUM_FLOWS];
        exp_f = '{f0, f1, f2, f3};
        for (int i = 0; i < NUM_FLOWS; i++) begin
            cnt_sel = FIDX_W'(i);
            #1;
            check($sformatf("%s_flow%0d", tag, i), 64'(cnt_out), 64'(exp_f[i]));
        end
        check({tag, "_total"},   64'(total_out),   64'(tot));
        check({tag, "_unknown"}, 64'(unknown_out), 64'(unk));
        check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int bad;
        int n;
        for (int i = 0; i < NUM_FLOWS; i++) mdl_flow[i] = 0;

        // reset state
        rst = 1'b1;
        tick(3);
        check("rst_rd_req",  64'(rd_req),      64'd0);
        check("rst_busy",    64'(busy),        64'd0);
        check("rst_done",    64'(done),        64'd0);
        check("rst_total",   64'(total_out),   64'd0);
        check("rst_unknown", 64'(unknown_out), 64'd0);
        check("rst_cnt",     64'(cnt_out),     64'd0);
        rst = 1'b0;
        tick(2);

        // 1: 32 reads cycling flows 0..3
        for (int i = 0; i < 32; i++) word_q.push_back(DATA_W'(i % 4));
        start_run(32);
        wait_done(400, "s1_done_seen");
        tick(3);
        check("s1_req_count", 64'(req_q.size()), 64'd32);
        bad = 0;
        for (int i = 1; i < req_q.size(); i++)
            if (req_q[i] - req_q[i-1] != GAP + 1) bad++;
        check("s1_req_spacing", 64'(bad), 64'd0);
        check("s1_done_count", 64'(done_cnt), 64'd1);
        check("s1_done_after_last", 64'(done_cyc - req_q[req_q.size()-1] >= RD_LATENCY), 64'd1);
        check("s1_busy_after", 64'(busy), 64'd0);
        check_counts("s1", 8*INC, 8*INC, 8*INC, 8*INC, 32*INC, 0);

        // 2: buffer empty stall for 20 cycles
        for (int i = 0; i < 4; i++) word_q.push_back(DATA_W'(i));
        buffer_empty = 1'b1;
        start_run(4);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (rd_req !== 1'b0 || busy !== 1'b1) bad++;
            @(negedge clk);
        end
        check("s2_hold_quiet_busy", 64'(bad), 64'd0);
        check("s2_no_req_in_hold", 64'(req_q.size()), 64'd0);
        buffer_empty = 1'b0;
        wait_done(200, "s2_done_seen");
        tick(2);
        check("s2_req_count", 64'(req_q.size()), 64'd4);
        check_counts("s2", INC, INC, INC, INC, 4*INC, 0);

        // 3: three out-of-range words among ten
        foreach (word_q[i]) ;
        begin
            int pat [10];
            pat = '{0, 9, 1, 2, 9, 3, 0, 9, 1, 2};
            for (int i = 0; i < 10; i++) word_q.push_back(DATA_W'(pat[i]));
        end
        start_run(10);
        wait_done(300, "s3_done_seen");
        tick(2);
        check_counts("s3", 2*INC, 2*INC, 2*INC, INC, 7*INC, 3*INC);

        // 4a: zero-length run
        start_run(0);
        wait_done(3, "s4_zero_done_fast");
        check("s4_zero_no_req", 64'(req_q.size()), 64'd0);
        tick(1);
        check_counts("s4z", 0, 0, 0, 0, 0, 0);

        // 4b: start while busy is ignored
        for (int i = 0; i < 10; i++) word_q.push_back(DATA_W'($urandom_range(0, 3)));
        start_run(10);
        tick(5);
        num_reads = NREQ_W'(3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(300, "s4_busy_done_seen");
        tick(3);
        check("s4_req_count", 64'(req_q.size()), 64'd10);
        check("s4_done_count", 64'(done_cnt), 64'd1);
        check_counts("s4", mdl_flow[0], mdl_flow[1], mdl_flow[2], mdl_flow[3], 10*INC, 0);

        // 5: reset mid-run
        word_q.delete();
        for (int i = 0; i < 16; i++) word_q.push_back(DATA_W'(i % 4));
        start_run(16);
        n = 0;
        while (n < 100 && req_q.size() < 2) begin
            @(negedge clk);
            n++;
        end
        check("s5_two_reqs", 64'(req_q.size() >= 2), 64'd1);
        tick(2);
        rst = 1'b1;
        @(negedge clk);
        check("s5_rst_rd_req",  64'(rd_req),      64'd0);
        check("s5_rst_busy",    64'(busy),        64'd0);
        check("s5_rst_done",    64'(done),        64'd0);
        check("s5_rst_total",   64'(total_out),   64'd0);
        check("s5_rst_unknown", 64'(unknown_out), 64'd0);
        cnt_sel = '0;
        #1;
        check("s5_rst_cnt0",    64'(cnt_out),     64'd0);
        rst = 1'b0;
        tick(20);
        check("s5_no_done", 64'(done_cnt), 64'd0);
        check("s5_idle_after", 64'(busy), 64'd0);
        check("s5_quiet_total", 64'(total_out), 64'd0);

        word_q.delete();
        begin
            int pat [8];
            pat = '{3, 3, 2, 1, 0, 0, 0, 1};
            for (int i = 0; i < 8; i++) word_q.push_back(DATA_W'(pat[i]));
        end
        start_run(8);
        wait_done(300, "s5_clean_done_seen");
        tick(2);
        check("s5_clean_req_count", 64'(req_q.size()), 64'd8);
        check_counts("s5c", 3*INC, 2*INC, INC, 2*INC, 8*INC, 0);

        tick(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/wfq_dequeue_reader.md
Name: wfq_dequeue_reader

Overview:
Synthesizable dequeue-side client for the WFQ scheduler output.
- Issues paced single-cycle read requests while the packet buffer is non-empty.
- Aligns the returned 64-bit data word to a fixed read latency and classifies each word by flow index.
- Keeps per-flow service counters that firmware or a bench reads to check weighted fairness. It is the reader at the opposite end of the scheduler's packet-write interface.

Parameters:
NUM_FLOWS, 4, number of flows tracked; flow index = data_in[FIDX_W-1:0], FIDX_W = clog2(NUM_FLOWS)
DATA_W, 64, width of scheduler output data word
RD_LATENCY, 7, cycles from rd_req high at a clock edge to the edge where data_in is valid
GAP, 1, idle cycles inserted after each issued request
CNT_W, 32, width of each service counter
NREQ_W, 16, width of read-count request

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse; begin a read run
num_reads  in  NREQ_W  number of requests in the run; sampled on start
buffer_empty  in  1  scheduler packet buffer empty flag
data_in  in  DATA_W  scheduler output data
rd_req  out  1  read request pulse to scheduler
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
cnt_sel  in  FIDX_W  flow selector for cnt_out
cnt_out  out  CNT_W  counter of selected flow, combinational mux of registers
total_out  out  CNT_W  sum of all flow counters (registered running total)
unknown_out  out  CNT_W  words whose value is >= NUM_FLOWS or whose upper bits are non-zero

Behaviour:
Reset:
- rd_req, busy and done = 0.
- All counters, total and unknown = 0.
- Latency pipe = 0; FSM = IDLE.

FSM states: IDLE, ISSUE, SPACE, DRAIN, DONE.
- IDLE: start=1 → clear all counters; latch remaining = num_reads.
  - remaining = 0 → go to DRAIN.
  - Otherwise → go to ISSUE.
- ISSUE: if buffer_empty=0, drive rd_req=1 for this cycle, decrement remaining, go to SPACE. If buffer_empty=1, hold in ISSUE with rd_req=0 (stall, no timeout).
- SPACE: wait GAP cycles. Then remaining = 0 → DRAIN; otherwise → ISSUE. GAP=0 means SPACE lasts 0 cycles, so back-to-back requests are allowed.
- DRAIN: wait until the latency pipe holds no pending valid, then go to DONE.
- DONE: done=1 for one cycle → IDLE.
- busy = 1 in every state except IDLE.
- start while busy is ignored. Counters hold their values after DONE until the next start.

Latency pipe:
- RD_LATENCY-deep shift register of rd_req.
- Tap RD_LATENCY-1 high → capture data_in at that edge.
- Fully pipelined: overlapping requests are each counted exactly once.

Classification:
- If data_in[DATA_W-1:FIDX_W] = 0 and data_in[FIDX_W-1:0] < NUM_FLOWS → increment that flow counter and total.
- Otherwise → increment unknown only.

Arithmetic:
- All counters saturate at 2^CNT_W-1; no wrap-around.
- Increment amount = 1 per word.

Reset mid-run: reset aborts immediately and clears everything, including in-flight pipe entries. No done pulse is produced.

Optional Feature:
WFQ_RD_BYTE_COUNT_EN
- Defined: flow counters, total and unknown add DATA_W/8 (8 bytes) per word, giving bytes served, still saturating.
- Undefined: they add 1 per word.

Decomposition:
- Package wfq_rd_pkg holds:
  - FSM state enum (IDLE, ISSUE, SPACE, DRAIN, DONE)
  - default NUM_FLOWS and RD_LATENCY constants
  - byte-per-word constant DATA_W/8
  - a saturating-add function
- Sub-module wfq_rd_latency_pipe: parameterized RD_LATENCY shift register with a pending-any output, used by DRAIN.

Test Plan:
1. Reset, write 32 words cycling flows 0..3 into a model scheduler, start with num_reads=32, GAP=1 → 32 rd_req pulses spaced 2 cycles apart; each flow count = 8; total = 32; unknown = 0; one done pulse ≥7 cycles after last rd_req.
2. buffer_empty held high for 20 cycles after start with num_reads=4 → no rd_req during hold; after release, 4 requests issued; counts correct; busy high throughout.
3. Model returns value 9 on 3 of 10 reads (NUM_FLOWS=4) → unknown = 3, total = 7.
4. start with num_reads=0 → no rd_req; done pulses within 3 cycles; all counters 0. A second start while busy in a 10-read run → ignored, exactly 10 requests.
5. rst asserted 3 cycles after the 2nd rd_req of a 16-read run → next cycle all outputs 0, no done pulse; a following clean run counts correctly with no leftover captures.
6. With WFQ_RD_BYTE_COUNT_EN defined, repeat scenario 1 → each flow count = 64, total = 256.
